// File: rtl/lsu_mem.sv
// Data-side load/store unit: one memory operation at a time over a valid/ready bus,
// with store lane steering and load byte-lane extraction plus sign/zero extension.
module lsu_mem #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             mem_wr,
    input  logic [2:0]       mem_op,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             bus_req_valid,
    input  logic             bus_req_ready,
    output logic [WIDTH-1:0] bus_addr,
    output logic             bus_we,
    output logic [3:0]       bus_wstrb,
    output logic [WIDTH-1:0] bus_wdata,
    input  logic             bus_rsp_valid,
    input  logic [WIDTH-1:0] bus_rdata,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            state;
    logic [7:0]        cnt;
    logic [2:0]        op_q;
    logic [1:0]        off_q;

    logic              illegal;
    logic [3:0]        strb_n;
    logic [WIDTH-1:0]  wdata_n;
    logic [WIDTH-1:0]  shifted;
    logic [WIDTH-1:0]  load_ext;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // The core side transfers in IDLE; the bus request transfers in REQ, with all bus_*
    // payload held stable from registers until then. Responses are single-cycle pulses
    // with no back-pressure on either side.
    assign req_ready     = (state == S_IDLE);
    assign bus_req_valid = (state == S_REQ);
    assign resp_valid    = (state == S_RESP);
    assign dbg_state     = state;

    always_comb begin
        illegal = 1'b0;
        strb_n  = 4'b0000;
        wdata_n = wdata;
        case (mem_op)
            3'b000, 3'b100: begin
                illegal = mem_wr && mem_op[2];
                strb_n  = 4'b0001 << addr[1:0];
                wdata_n = {4{wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                illegal = addr[0] || (mem_wr && mem_op[2]);
                strb_n  = 4'b0011 << {addr[1], 1'b0};
                wdata_n = {2{wdata[15:0]}};
            end
            3'b010: begin
                illegal = (addr[1:0] != 2'b00);
                strb_n  = 4'b1111;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (!mem_wr) begin
            strb_n = 4'b0000;
        end
    end

    // Load path: bring the addressed lane down to bit 0, then extend; mem_op[2] selects zero-extend.
    always_comb begin
        shifted  = bus_rdata >> {off_q, 3'b000};
        load_ext = shifted;
        case (op_q[1:0])
            2'b00:   load_ext = {{24{~op_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{~op_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            op_q       <= 3'b000;
            off_q      <= 2'b00;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            bus_addr   <= '0;
            bus_we     <= 1'b0;
            bus_wstrb  <= 4'b0000;
            bus_wdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q       <= mem_op;
                        off_q      <= addr[1:0];
                        bus_addr   <= {addr[WIDTH-1:2], 2'b00};
                        bus_we     <= mem_wr;
                        bus_wstrb  <= strb_n;
                        bus_wdata  <= wdata_n;
                        resp_rdata <= '0;
                        resp_err   <= illegal;
                        state      <= illegal ? S_RESP : S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_req_ready) begin
                        cnt   <= 8'd0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus_rsp_valid) begin
                        if (!bus_we) begin
                            resp_rdata <= load_ext;
                        end
                        resp_err <= 1'b0;
                        state    <= S_RESP;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th WAIT cycle without a response.
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem.sv
// Self-checking bench for lsu_mem: directed test-plan cases, reset abandonment and
// randomized operations against an arithmetic reference model with a bus responder.
module tb_lsu_mem;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        mem_wr;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_err_q[$];

    lsu_mem #(.WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .mem_wr(mem_wr), .mem_op(mem_op), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // reference model
    function automatic bit is_legal(input logic wr, input logic [2:0] op, input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        case (op)
            3'd0:    return 1'b1;
            3'd4:    return !wr;
            3'd1:    return (off % 2) == 0;
            3'd5:    return ((off % 2) == 0) && !wr;
            3'd2:    return off == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] w);
        int unsigned v, b, h;
        v = w / (32'd1 << (8 * (a % 4)));
        b = v % 256;
        h = v % 65536;
        case (op)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd5:    return h;
            default: return v;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] op, input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        case (op % 4)
            0:       return 4'(1 << off);
            1:       return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] w);
        case (op % 4)
            0:       return (w % 256) * 32'h0101_0101;
            1:       return (w % 65536) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    // driver + bus responder; called and returns on a falling edge with the DUT in IDLE
    task automatic run_op(input logic wr, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rword,
                          input int req_delay, input int rsp_delay);
        bit legal, hs, seen_req, done;
        int cyc, stalls, waits, exp_lat;
        logic [31:0] e_rd, e_err;
        legal = is_legal(wr, op, a);
        if (!legal) begin
            e_rd = 0; e_err = 1; exp_lat = 1;
        end else if (rsp_delay < 0 || rsp_delay >= TO) begin
            e_rd = 0; e_err = 1; exp_lat = 3 + req_delay + TO - 1;
        end else begin
            e_rd = wr ? 32'd0 : model_load(op, a, rword);
            e_err = 0;
            exp_lat = 3 + req_delay + rsp_delay;
        end
        exp_q.push_back(e_rd);
        exp_err_q.push_back(e_err);

        check("req_ready_idle", req_ready, 1);
        req_valid = 1; mem_wr = wr; mem_op = op; addr = a; wdata = wd;
        @(negedge clk);
        req_valid = 0; mem_wr = 1'($urandom); mem_op = 3'($urandom); addr = $urandom; wdata = $urandom;
        cyc = 1; stalls = 0; waits = 0; hs = 0; seen_req = 0; done = 0;
        while (!done && cyc < 400) begin
            bus_req_ready = 0; bus_rsp_valid = 0; bus_rdata = $urandom;
            if (resp_valid) begin
                done = 1;
                check("latency", cyc, exp_lat);
                check("resp_rdata", resp_rdata, exp_q.pop_front());
                check("resp_err", resp_err, exp_err_q.pop_front());
                bus_rsp_valid = 1'($urandom);
            end else if (bus_req_valid) begin
                seen_req = 1;
                if (!legal) check("illegal_bus_req", bus_req_valid, 0);
                check("bus_addr", bus_addr, a - (a % 4));
                check("bus_we", bus_we, wr);
                check("bus_wstrb", bus_wstrb, wr ? model_strb(op, a) : 4'b0000);
                if (wr) check("bus_wdata", bus_wdata, model_wdata(op, wd));
                if (stalls < req_delay) begin
                    stalls++;
                    bus_rsp_valid = 1'($urandom);
                end else begin
                    bus_req_ready = 1;
                    hs = 1;
                end
            end else if (hs) begin
                if (waits == rsp_delay) begin
                    bus_rsp_valid = 1;
                    bus_rdata = rword;
                end
                waits++;
            end
            @(negedge clk);
            cyc++;
        end
        bus_req_ready = 0; bus_rsp_valid = 0;
        check("resp_seen", done, 1);
        check("bus_req_seen", seen_req, legal);
        if (!done) begin
            exp_q.delete();
            exp_err_q.delete();
        end
    endtask

    task automatic stale_rsp(input string tag);
        bus_rsp_valid = 1; bus_rdata = $urandom;
        @(negedge clk);
        bus_rsp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            check(tag, resp_valid, 0);
            check({tag, "_state"}, dbg_state, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 0; req_valid = 0; mem_wr = 0; mem_op = 0; addr = 0; wdata = 0;
        bus_req_ready = 0; bus_rsp_valid = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_bus_req_valid", bus_req_valid, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_wstrb", bus_wstrb, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);

        // test plan cases
        run_op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 0, 0);
        run_op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0);
        run_op(1'b1, 3'b001, 32'h0000_3002, 32'hDEAD_BEEF, 32'h0, 0, 0);
        run_op(1'b0, 3'b010, 32'h0000_4001, 32'h0, 32'h0, 0, 0);
        run_op(1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h1234_5678, 5, -1);
        stale_rsp("late_rsp_after_timeout");
        run_op(1'b0, 3'b001, 32'h0000_6002, 32'h0, 32'h8000_0000, 1, TO - 1);
        run_op(1'b1, 3'b100, 32'h0000_7000, 32'h0, 32'h0, 0, 0);
        run_op(1'b0, 3'b111, 32'h0000_7000, 32'h0, 32'h0, 0, 0);

        // reset in WAIT abandons the transaction
        req_valid = 1; mem_wr = 0; mem_op = 3'b010; addr = 32'h0000_8000;
        @(negedge clk);
        req_valid = 0; bus_req_ready = 1;
        @(negedge clk);
        bus_req_ready = 0;
        check("in_wait", dbg_state, 2);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        check("rst_wait_state", dbg_state, 0);
        check("rst_wait_req_ready", req_ready, 1);
        check("rst_wait_resp_valid", resp_valid, 0);
        check("rst_wait_bus_req_valid", bus_req_valid, 0);
        stale_rsp("stale_rsp_after_reset");

        // randomized operations
        for (int i = 0; i < 80; i++) begin
            logic [31:0] ra;
            int rd;
            ra = $urandom;
            rd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO + 1));
            run_op(1'($urandom), 3'($urandom_range(0, 7)), ra, $urandom, $urandom,
                   int'($urandom_range(0, 3)), rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem.md
# lsu_mem

Data-side load/store unit for the RV32I single-cycle core. It consumes the decoder's `MemWr`/`MemOP` encoding together with the ALU address and rs2 data, and runs one transaction at a time over a valid/ready data bus. Before returning load data to writeback, it performs byte-lane steering and sign or zero extension. It sits between the execute stage and the data-memory port; the instruction-fetch path is separate.

## Interface
- `WIDTH`, 32: data and address width. Only 32 is supported.
- `TIMEOUT`, 255: the number of WAIT cycles without a bus response before the unit aborts with an error. The range is 1..255.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst_n` in 1: synchronous reset, active low.
- `req_valid` in 1: the core presents a memory operation.
- `req_ready` out 1: the unit can accept an operation. High only in IDLE.
- `mem_wr` in 1: 1 = store, 0 = load.
- `mem_op` in 3:
  - 000 = byte, signed
  - 001 = half, signed
  - 010 = word
  - 100 = byte, unsigned
  - 101 = half, unsigned
  - 111 = none
- `addr` in 32: byte address.
- `wdata` in 32: store data, taken from rs2.
- `resp_valid` out 1: a one-cycle pulse marking completion.
- `resp_rdata` out 32: the extended load result. It is 0 for stores and for errors.
- `resp_err` out 1: set for misalignment, an illegal op, or a timeout. Valid with `resp_valid`.
- `bus_req_valid` out 1: a bus request is pending.
- `bus_req_ready` in 1: the memory accepts the request.
- `bus_addr` out 32: the word-aligned address, `{addr[31:2],2'b00}`.
- `bus_we` out 1: write enable.
- `bus_wstrb` out 4: byte-lane strobes. 0000 on loads.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_rsp_valid` in 1: a one-cycle response pulse. It is the read-data strobe for loads and the write acknowledge for stores.
- `bus_rdata` in 32: the full word read.

## Operation
The unit is a state machine with four states: IDLE, REQ, WAIT and RESP.

**IDLE**
- `req_ready` = 1.
- On `req_valid`, the unit latches `mem_wr`, `mem_op`, `addr` and `wdata`, then checks legality.

**Illegal operations** go straight to RESP with `resp_err` = 1, and no bus traffic is issued. An operation is illegal if any of the following holds:
- `mem_op` = 111.
- `mem_op` = 011 or 110.
- A store with `mem_op` = 100 or 101.
- A half-word access with `addr[0]` = 1.
- A word access with `addr[1:0]` ≠ 00.

**Legal operations** go to REQ.

**REQ**
- `bus_req_valid` = 1. `bus_addr`, `bus_we`, `bus_wstrb` and `bus_wdata` come from registers and stay stable until the handshake.
- On `bus_req_ready` = 1, the unit moves to WAIT and clears the timeout counter.
- A `bus_rsp_valid` pulse that arrives in REQ is ignored.

**Store lane steering**
- Byte: `wstrb` = 0001 << `addr[1:0]`; `wdata` = `{4{wdata[7:0]}}`.
- Half: `wstrb` = 0011 << {`addr[1]`,0}; `wdata` = `{2{wdata[15:0]}}`.
- Word: `wstrb` = 1111; `wdata` unchanged.

**WAIT**
- The counter increments each cycle.
- On `bus_rsp_valid`:
  - For a load, the unit shifts `bus_rdata` right by 8·`addr[1:0]`, extends the result according to `mem_op`, and registers it into `resp_rdata`.
  - The unit then moves to RESP with `resp_err` = 0.
- If the counter reaches `TIMEOUT` with no response, the unit moves to RESP with `resp_err` = 1 and `resp_rdata` = 0.

**RESP**
- `resp_valid` = 1 for exactly one cycle, then the unit returns to IDLE.
- There is no back-pressure on the response side.

**Late responses**: a `bus_rsp_valid` pulse that arrives in IDLE or RESP (for example, after a timeout or a reset) is discarded.

## Timing
- **Reset** (`rst_n` = 0 at a rising edge):
  - state = IDLE, counter = 0, `resp_rdata` = 0, `resp_err` = 0.
  - Resulting outputs: `resp_valid` = 0, `bus_req_valid` = 0, `bus_we` = 0, `bus_wstrb` = 0, `req_ready` = 1.
  - Reset in any state abandons the transaction with no response.
- **Minimum latency**: with `bus_req_ready` already high and the response in the next cycle:
  - cycle 0: request accepted.
  - cycle 1: REQ handshake.
  - cycle 2: `bus_rsp_valid`.
  - cycle 3: `resp_valid`.
- **Error latency**: `resp_valid` asserts in the cycle after acceptance.
- **Back-to-back operations**: the next request is accepted in the cycle after RESP, giving a throughput of one operation per 4 cycles or more.
- **Output derivation**: all `bus_*` outputs and `resp_*` outputs are driven from registers or decoded from state only. There is no combinational path from `req_*` or `bus_rsp_*` to outputs.

## Test plan
- **Signed byte load**: load `mem_op` = 000, `addr` = 0x1003, `bus_rdata` = 0x80FFFFFF.
  - `bus_addr` = 0x1000, `bus_wstrb` = 0000.
  - `resp_rdata` = 0xFFFFFF80, `resp_err` = 0.
  - `resp_valid` asserts 3 cycles after acceptance.
- **Unsigned half load**: `mem_op` = 101, `addr` = 0x2002, `bus_rdata` = 0x8001_1234 → `resp_rdata` = 0x00008001.
- **Half store**: `mem_wr` = 1, `mem_op` = 001, `addr` = 0x3002, `wdata` = 0xDEADBEEF.
  - `bus_wstrb` = 1100, `bus_wdata` = 0xBEEFBEEF, `bus_we` = 1.
  - After the acknowledge: `resp_rdata` = 0.
- **Misaligned word**: `mem_op` = 010, `addr` = 0x4001.
  - No `bus_req_valid` ever asserts.
  - `resp_valid` and `resp_err` assert in the next cycle.
- **Back-pressure then timeout** (`TIMEOUT` = 4):
  - Hold `bus_req_ready` low for 5 cycles: outputs stay stable and there is no timeout.
  - Then accept the request and never respond: `resp_err` = 1 after 4 WAIT cycles.
  - A later `bus_rsp_valid` is ignored.
- **Reset mid-WAIT**: drive `rst_n` low for 1 cycle in WAIT.
  - Next cycle: state IDLE, `req_ready` = 1, no `resp_valid`.
  - A subsequent stale `bus_rsp_valid` produces no response.
